// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared scan phase encoding, digit-select table and nibble helper
package smg_pkg;

  typedef enum logic [1:0] {
    PH_GUARD = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_e;

  localparam logic [3:0] SCAN_OFF = 4'b1111;

  // Active-low digit enables; entry [k] drives digit k.
  localparam logic [3:0][3:0] DIGIT_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [3:0] nibbleOf(input logic [15:0] num, input logic [1:0] idx);
    case (idx)
      2'd0:    return num[15:12];
      2'd1:    return num[11:8];
      2'd2:    return num[7:4];
      default: return num[3:0];
    endcase
  endfunction

endpackage

// File: rtl/smg_digit_suppress.sv
// rtl/smg_digit_suppress.sv - per-digit dark vector from blank mask and leading-zero suppression
module smg_digit_suppress (
  input  logic [15:0] numberSnap,
  input  logic [3:0]  blankMask,
  input  logic        lzsEn,
  output logic [3:0]  dark
);

  logic z0, z01, z012;

  always_comb begin
    z0   = (numberSnap[15:12] == 4'd0);
    z01  = z0 && (numberSnap[11:8] == 4'd0);
    z012 = z01 && (numberSnap[7:4] == 4'd0);
    // The rightmost digit always shows, so an all-zero value still reads "0".
    dark[0] = blankMask[0] | (lzsEn & z0);
    dark[1] = blankMask[1] | (lzsEn & z01);
    dark[2] = blankMask[2] | (lzsEn & z012);
    dark[3] = blankMask[3];
  end

endmodule

// File: rtl/smg_scan_scheduler.sv
// rtl/smg_scan_scheduler.sv - 4-digit 7-segment scan: guard/on/off slots, PWM, tear-free frame snapshot
module smg_scan_scheduler
  import smg_pkg::*;
#(
  parameter int T_SLOT  = 500_000,
  parameter int T_GUARD = 2_500,
  parameter int CW      = 19
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [15:0] NumberSig,
  input  logic [3:0]  BlankMask,
  input  logic [2:0]  Brightness,
  input  logic        LzsEn,
  output logic [3:0]  ScanSig,
  output logic [3:0]  NumberData,
  output logic [1:0]  DigitIdx,
  output logic        FrameDone
);

  localparam logic [1:0]    ST_GUARD  = PH_GUARD;
  localparam logic [1:0]    ST_ON     = PH_ON;
  localparam logic [1:0]    ST_OFF    = PH_OFF;
  localparam logic [CW-1:0] SLOT_LAST = CW'(T_SLOT - 1);
  localparam logic [CW:0]   GUARD_END = (CW+1)'(T_GUARD);
  localparam logic [CW:0]   ON_UNIT   = (CW+1)'((T_SLOT - T_GUARD) >> 3);

  logic [CW-1:0] slotCnt, cntNext;
  logic [1:0]    state, stateNext, idxNext;
  logic [15:0]   snapNum, numNext;
  logic [3:0]    snapMask, maskNext, dark;
  logic [2:0]    snapBright, brightNext;
  logic          snapLzs, lzsNext, snapLoad, slotEnd;
  logic [CW:0]   onEnd;

  // Outputs are registered from next-cycle values, so everything downstream sees
  // the snapshot that will be live in the cycle the output is shown.
  always_comb begin
    snapLoad   = (DigitIdx == 2'd0) && (slotCnt == '0);
    numNext    = snapLoad ? NumberSig  : snapNum;
    maskNext   = snapLoad ? BlankMask  : snapMask;
    brightNext = snapLoad ? Brightness : snapBright;
    lzsNext    = snapLoad ? LzsEn      : snapLzs;
    slotEnd    = (slotCnt == SLOT_LAST);
    cntNext    = slotEnd ? '0 : slotCnt + 1'b1;
    idxNext    = slotEnd ? DigitIdx + 2'd1 : DigitIdx;
    onEnd      = GUARD_END + ON_UNIT * {{(CW-3){1'b0}}, {1'b0, brightNext} + 4'd1};

    // At full brightness onEnd can equal T_SLOT; ON then runs until the slot wraps.
    stateNext = state;
    if (slotEnd) begin
      stateNext = ST_GUARD;
    end else begin
      case (state)
        ST_GUARD: if ({1'b0, cntNext} == GUARD_END) stateNext = ST_ON;
        ST_ON:    if ({1'b0, cntNext} == onEnd) stateNext = ST_OFF;
        default:  stateNext = ST_OFF;
      endcase
    end
  end

  smg_digit_suppress u_suppress (
    .numberSnap(numNext),
    .blankMask (maskNext),
    .lzsEn     (lzsNext),
    .dark      (dark)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      slotCnt    <= '0;
      DigitIdx   <= 2'd0;
      state      <= ST_GUARD;
      snapNum    <= '0;
      snapMask   <= '0;
      snapBright <= '0;
      snapLzs    <= 1'b0;
      ScanSig    <= SCAN_OFF;
      NumberData <= 4'd0;
      FrameDone  <= 1'b0;
    end else begin
      slotCnt  <= cntNext;
      DigitIdx <= idxNext;
      state    <= stateNext;
      if (snapLoad) begin
        snapNum    <= NumberSig;
        snapMask   <= BlankMask;
        snapBright <= Brightness;
        snapLzs    <= LzsEn;
      end
      ScanSig    <= (stateNext == ST_ON && !dark[idxNext]) ? DIGIT_SEL[idxNext] : SCAN_OFF;
      NumberData <= nibbleOf(numNext, idxNext);
      FrameDone  <= (idxNext == 2'd3) && (cntNext == SLOT_LAST);
    end
  end

endmodule

// File: tb/tb_smg_scan_scheduler.sv
// tb/tb_smg_scan_scheduler.sv - randomized self-checking bench with a frame-level reference model
module tb_smg_scan_scheduler;

  localparam int TS   = 80;
  localparam int TG   = 8;
  localparam int UNIT = (TS - TG) / 8;
  localparam int FR   = 4 * TS;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [15:0] NumberSig = '0;
  logic [3:0]  BlankMask = '0;
  logic [2:0]  Brightness = '0;
  logic        LzsEn = 1'b0;
  logic [3:0]  ScanSig, NumberData;
  logic [1:0]  DigitIdx;
  logic        FrameDone;

  smg_scan_scheduler #(.T_SLOT(TS), .T_GUARD(TG), .CW(7)) dut (
    .CLK(CLK), .RSTn(RSTn), .NumberSig(NumberSig), .BlankMask(BlankMask),
    .Brightness(Brightness), .LzsEn(LzsEn), .ScanSig(ScanSig),
    .NumberData(NumberData), .DigitIdx(DigitIdx), .FrameDone(FrameDone)
  );

  always #5 CLK = ~CLK;

  int passCnt = 0;
  int totalCnt = 0;
  int t = 0;

  logic [15:0] mNum;
  logic [3:0]  mMask;
  int          mBright;
  bit          mLzs;
  logic [3:0]  expScan, expData;
  logic [1:0]  expIdx;
  logic        expDone;
  bit          dataValid;

  logic [15:0] cNum[4];
  logic [3:0]  cMask[4];
  logic [2:0]  cBright[4];
  bit          cLzs[4];
  bit          cNoise;

  function automatic logic [3:0] nib(input logic [15:0] n, input int k);
    return n[15-4*k -: 4];
  endfunction

  function automatic bit isDark(input int k);
    if (mMask[k]) return 1'b1;
    if (!mLzs || k == 3) return 1'b0;
    for (int j = 0; j <= k; j++) if (nib(mNum, j) != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelStep();
    int k, c;
    if (t % FR == 0) begin
      mNum = NumberSig; mMask = BlankMask; mBright = int'(Brightness); mLzs = LzsEn;
    end
    k = (t / TS) % 4;
    c = t % TS;
    expIdx  = 2'(k);
    expDone = (k == 3 && c == TS - 1);
    expScan = (c >= TG && c < TG + UNIT * (mBright + 1) && !isDark(k)) ? ~(4'b0001 << k) : 4'hF;
    expData = (t == 0) ? 4'h0 : nib(mNum, k);
    dataValid = (t == 0) || (c != 0) || (k != 0);
    t++;
  endtask

  task automatic driveNext();
    int f;
    f = (t / FR) % 4;
    if (cNoise && (t % FR) != 0) begin
      NumberSig = 16'($urandom); BlankMask = 4'($urandom);
      Brightness = 3'($urandom); LzsEn = 1'($urandom);
    end else begin
      NumberSig = cNum[f]; BlankMask = cMask[f]; Brightness = cBright[f]; LzsEn = cLzs[f];
    end
  endtask

  task automatic doReset();
    t = 0;
    driveNext();
    RSTn = 1'b0;
    @(negedge CLK);
    modelStep();
    RSTn = 1'b1;
  endtask

  task automatic setAll(input logic [15:0] n, input logic [3:0] m, input logic [2:0] b, input bit l);
    for (int i = 0; i < 4; i++) begin
      cNum[i] = n; cMask[i] = m; cBright[i] = b; cLzs[i] = l;
    end
  endtask

  task automatic test_reset();
    setAll(16'h1234, 4'h0, 3'd7, 1'b0);
    cNoise = 1'b1;
    doReset();
    totalCnt++; if (ScanSig !== 4'hF) $display("FAIL reset_scan got %h exp f", ScanSig); else passCnt++;
    totalCnt++; if (DigitIdx !== 2'd0) $display("FAIL reset_idx got %0d exp 0", DigitIdx); else passCnt++;
    totalCnt++; if (NumberData !== 4'd0) $display("FAIL reset_data got %h exp 0", NumberData); else passCnt++;
    totalCnt++; if (FrameDone !== 1'b0) $display("FAIL reset_done got %b exp 0", FrameDone); else passCnt++;
  endtask

  task automatic test_full_bright();
    while (t < 2 * FR) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL full_bright t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL full_bright_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  task automatic test_brightness();
    for (int i = 0; i < 4; i++) begin
      cNum[i] = 16'($urandom); cMask[i] = 4'h0; cLzs[i] = 1'b0;
      cBright[i] = (i == 0) ? 3'd0 : (i == 1) ? 3'd7 : 3'($urandom);
    end
    cNoise = 1'b1;
    doReset();
    while (t < 4 * FR) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL brightness t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL brightness_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  task automatic test_lzs();
    cNum[0] = 16'h0045; cNum[1] = 16'h0000;
    cNum[2] = 16'($urandom) >> (4 * $urandom_range(1, 3)); cNum[3] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      cLzs[i] = 1'b1;
      cMask[i] = (i < 2) ? 4'h0 : 4'($urandom);
      cBright[i] = (i < 2) ? 3'd7 : 3'($urandom);
    end
    cNoise = 1'b1;
    doReset();
    while (t < 4 * FR) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL lzs t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL lzs_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  task automatic test_tearing();
    setAll(16'hABCD, 4'h0, 3'd7, 1'b0);
    cNum[0] = 16'h1234;
    cNoise = 1'b0;
    doReset();
    while (t < 2 * FR) begin
      @(posedge CLK); #1; driveNext();
      if (t >= TS + 20) NumberSig = 16'hABCD;
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL tearing t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL tearing_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  task automatic test_mask_all();
    for (int i = 0; i < 4; i++) begin
      cNum[i] = 16'($urandom); cBright[i] = 3'($urandom); cLzs[i] = 1'($urandom);
      cMask[i] = (i < 2) ? 4'hF : 4'($urandom);
    end
    cNoise = 1'b1;
    doReset();
    while (t < 4 * FR) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL mask_all t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL mask_all_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    setAll(16'h1234, 4'h0, 3'd7, 1'b0);
    cNoise = 1'b1;
    doReset();
    while (t <= 2 * TS + 20) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
    end
    totalCnt++;
    if (ScanSig !== 4'b1011) $display("FAIL mid_pre_scan got %h exp b", ScanSig); else passCnt++;
    setAll(16'h5678, 4'h0, 3'd7, 1'b0);
    doReset();
    totalCnt++; if (ScanSig !== 4'hF) $display("FAIL mid_reset_scan got %h exp f", ScanSig); else passCnt++;
    totalCnt++; if (DigitIdx !== 2'd0) $display("FAIL mid_reset_idx got %0d exp 0", DigitIdx); else passCnt++;
    totalCnt++; if (NumberData !== 4'd0) $display("FAIL mid_reset_data got %h exp 0", NumberData); else passCnt++;
    totalCnt++; if (FrameDone !== 1'b0) $display("FAIL mid_reset_done got %b exp 0", FrameDone); else passCnt++;
    while (t < FR) begin
      @(posedge CLK); #1; driveNext();
      @(negedge CLK); modelStep();
      totalCnt++;
      if ({ScanSig, DigitIdx, FrameDone} !== {expScan, expIdx, expDone})
        $display("FAIL reset_mid t=%0d scan/idx/done got %h/%0d/%b exp %h/%0d/%b",
                 t-1, ScanSig, DigitIdx, FrameDone, expScan, expIdx, expDone);
      else passCnt++;
      if (dataValid) begin
        totalCnt++;
        if (NumberData !== expData) $display("FAIL reset_mid_data t=%0d got %h exp %h", t-1, NumberData, expData);
        else passCnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bright();
    test_brightness();
    test_lzs();
    test_tearing();
    test_mask_all();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
